// File: rtl/status_flags_reg_pkg.sv
// NZCV flag layout shared by the flag register and the condition evaluator.
package status_flags_reg_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] nzcv_t;

endpackage

// File: rtl/status_flags_reg_flag_stack.sv
// LIFO of saved NZCV sets; registered depth, combinational top entry and error pulse.
module flag_stack
  import status_flags_reg_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  nzcv_t            din,
  output nzcv_t            top,
  output logic [PTR_W-1:0] depth,
  output logic             full,
  output logic             empty,
  output logic             pop_ok,
  output logic             err
);

  // Storage is sized to the pointer range so any depth value indexes it directly.
  localparam int SLOTS = 1 << PTR_W;

  nzcv_t            mem [SLOTS];
  logic             push_ok;
  logic [PTR_W-1:0] top_idx;

  assign full    = (depth == PTR_W'(DEPTH));
  assign empty   = (depth == '0);
  assign push_ok = push & ~pop & ~full;
  assign pop_ok  = pop & ~push & ~empty;
  assign err     = (push & pop) | (push & full) | (pop & empty);
  assign top_idx = depth - PTR_W'(1);
  assign top     = mem[top_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      depth <= '0;
    end else if (push_ok) begin
      depth <= depth + PTR_W'(1);
    end else if (pop_ok) begin
      depth <= depth - PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[depth] <= din;
    end
  end

endmodule

// File: rtl/status_flags_reg.sv
// NZCV flag register with ALU/explicit-write update priority and an exception save stack.
// FLAG_BYPASS_EN adds byp_* outputs exposing the next-state flags combinationally.
module status_flags_reg
  import status_flags_reg_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int STACK_DEPTH = 4,
  parameter int PTR_W       = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  input  logic              op_logical,
  input  logic              set_flags,
  input  logic              cond_pass,
  input  logic              wr_en,
  input  logic [3:0]        wr_flags,
  input  logic              push,
  input  logic              pop,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_v,
  output logic [PTR_W-1:0]  depth,
  output logic              stack_full,
  output logic              stack_empty,
`ifdef FLAG_BYPASS_EN
  output logic              byp_n,
  output logic              byp_z,
  output logic              byp_c,
  output logic              byp_v,
`endif
  output logic              stack_err
);

  nzcv_t flags;
  nzcv_t flags_nxt;
  nzcv_t stack_top;
  logic  pop_ok;
  logic  err_pulse;

  flag_stack #(
    .DEPTH (STACK_DEPTH),
    .PTR_W (PTR_W)
  ) u_stack (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .din    (flags),
    .top    (stack_top),
    .depth  (depth),
    .full   (stack_full),
    .empty  (stack_empty),
    .pop_ok (pop_ok),
    .err    (err_pulse)
  );

  // A rejected pop falls through so a concurrent write or ALU update still lands.
  always_comb begin
    flags_nxt = flags;
    if (pop_ok) begin
      flags_nxt = stack_top;
    end else if (wr_en && cond_pass) begin
      flags_nxt = wr_flags;
    end else if (set_flags && cond_pass) begin
      flags_nxt[FLAG_N] = alu_result[DATA_W-1];
      flags_nxt[FLAG_Z] = (alu_result == '0);
      flags_nxt[FLAG_C] = alu_carry;
      if (!op_logical) begin
        flags_nxt[FLAG_V] = alu_overflow;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags     <= '0;
      stack_err <= 1'b0;
    end else begin
      flags <= flags_nxt;
      if (err_pulse) begin
        stack_err <= 1'b1;
      end
    end
  end

  assign flag_n = flags[FLAG_N];
  assign flag_z = flags[FLAG_Z];
  assign flag_c = flags[FLAG_C];
  assign flag_v = flags[FLAG_V];

`ifdef FLAG_BYPASS_EN
  assign byp_n = flags_nxt[FLAG_N];
  assign byp_z = flags_nxt[FLAG_Z];
  assign byp_c = flags_nxt[FLAG_C];
  assign byp_v = flags_nxt[FLAG_V];
`endif

endmodule

// File: tb/tb_status_flags_reg.sv
// Directed vectors feed an expectation queue; a monitor checks registered outputs each cycle.
module tb_status_flags_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] alu_result = '0;
  logic        alu_carry = 1'b0, alu_overflow = 1'b0, op_logical = 1'b0;
  logic        set_flags = 1'b0, cond_pass = 1'b0, wr_en = 1'b0;
  logic [3:0]  wr_flags = '0;
  logic        push = 1'b0, pop = 1'b0;
  logic        flag_n, flag_z, flag_c, flag_v;
  logic [2:0]  depth;
  logic        stack_full, stack_empty, stack_err;
`ifdef FLAG_BYPASS_EN
  logic        byp_n, byp_z, byp_c, byp_v;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      nm;
    logic [3:0] f;
    logic [2:0] d;
    logic       e;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  status_flags_reg #(.DATA_W(32), .STACK_DEPTH(4), .PTR_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .op_logical   (op_logical),
    .set_flags    (set_flags),
    .cond_pass    (cond_pass),
    .wr_en        (wr_en),
    .wr_flags     (wr_flags),
    .push         (push),
    .pop          (pop),
    .flag_n       (flag_n),
    .flag_z       (flag_z),
    .flag_c       (flag_c),
    .flag_v       (flag_v),
    .depth        (depth),
    .stack_full   (stack_full),
    .stack_empty  (stack_empty),
`ifdef FLAG_BYPASS_EN
    .byp_n        (byp_n),
    .byp_z        (byp_z),
    .byp_c        (byp_c),
    .byp_v        (byp_v),
`endif
    .stack_err    (stack_err)
  );

  // Drive one cycle of inputs and queue the registered state expected after the next edge.
  task automatic apply(input string nm, input logic r, input logic [31:0] res,
                       input logic c, input logic v, input logic lg, input logic sf,
                       input logic cp, input logic we, input logic [3:0] wf,
                       input logic pu, input logic po,
                       input logic [3:0] ef, input logic [2:0] ed, input logic ee);
    exp_t x;
    @(negedge clk);
    rst = r; alu_result = res; alu_carry = c; alu_overflow = v; op_logical = lg;
    set_flags = sf; cond_pass = cp; wr_en = we; wr_flags = wf; push = pu; pop = po;
    x.nm = nm; x.f = ef; x.d = ed; x.e = ee;
    q.push_back(x);
`ifdef FLAG_BYPASS_EN
    #1;
    if (!r) begin
      n_cmp++;
      if ({byp_n, byp_z, byp_c, byp_v} !== ef) begin
        n_bad++;
        $display("FAIL byp_%s: got %b want %b", nm, {byp_n, byp_z, byp_c, byp_v}, ef);
      end
    end
`endif
  endtask

  task automatic idle(input string nm, input logic [3:0] ef, input logic [2:0] ed, input logic ee);
    apply(nm, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, ef, ed, ee);
  endtask

  // Monitor: the flag register presents a new value every cycle.
  always @(posedge clk) begin
    exp_t x;
    logic [10:0] got, want;
    #1;
    if (q.size() != 0) begin
      x = q.pop_front();
      got  = {flag_n, flag_z, flag_c, flag_v, depth, stack_full, stack_empty, stack_err};
      want = {x.f, x.d, (x.d == 3'd4), (x.d == 3'd0), x.e};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL %s: got nzcv=%b depth=%0d full=%b empty=%b err=%b want nzcv=%b depth=%0d full=%b empty=%b err=%b",
                 x.nm, got[10:7], got[6:4], got[3], got[2], got[1],
                 want[10:7], want[6:4], want[3], want[2], want[1]);
      end
    end
  end

  initial begin
    int guard;
    //     name          rst res           c     v     lg    sf    cp    we    wf     pu    po    nzcv   d     err
    apply("reset",       1, 32'h0,        0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 4'b0000, 3'd0, 0);
    apply("alu_arith",   0, 32'h80000000, 1, 1, 0, 1, 1, 0, 4'h0, 0, 0, 4'b1011, 3'd0, 0);
    apply("alu_logical", 0, 32'h0,        0, 0, 1, 1, 1, 0, 4'h0, 0, 0, 4'b0101, 3'd0, 0);
    apply("cond_fail",   0, 32'hFFFFFFFF, 1, 1, 0, 1, 0, 0, 4'h0, 0, 0, 4'b0101, 3'd0, 0);
    apply("wr_beats_alu",0, 32'hFFFFFFFF, 1, 1, 0, 1, 1, 1, 4'b0110, 0, 0, 4'b0110, 3'd0, 0);
    apply("wr_1010",     0, 32'h0,        0, 0, 0, 0, 1, 1, 4'b1010, 0, 0, 4'b1010, 3'd0, 0);
    apply("push_alu",    0, 32'h0,        0, 0, 0, 1, 1, 0, 4'h0, 1, 0, 4'b0100, 3'd1, 0);
    idle ("hold",        4'b0100, 3'd1, 0);
    apply("pop_restore", 0, 32'h0,        0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 4'b1010, 3'd0, 0);
    // Fill with distinct saved sets so the drain order proves LIFO behaviour.
    apply("push1",       0, 32'h0,        0, 0, 0, 0, 1, 1, 4'b0011, 1, 0, 4'b0011, 3'd1, 0);
    apply("push2",       0, 32'h0,        0, 0, 0, 0, 1, 1, 4'b1100, 1, 0, 4'b1100, 3'd2, 0);
    apply("push3",       0, 32'h0,        0, 0, 0, 0, 1, 1, 4'b0111, 1, 0, 4'b0111, 3'd3, 0);
    apply("push4",       0, 32'h0,        0, 0, 0, 0, 0, 0, 4'h0, 1, 0, 4'b0111, 3'd4, 0);
    apply("push_full",   0, 32'h0,        0, 0, 0, 0, 1, 1, 4'b0001, 1, 0, 4'b0001, 3'd4, 1);
    apply("pop1",        0, 32'h0,        0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 4'b0111, 3'd3, 1);
    apply("pop2",        0, 32'h0,        0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 4'b1100, 3'd2, 1);
    apply("pop3",        0, 32'h0,        0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 4'b0011, 3'd1, 1);
    apply("pop4",        0, 32'h0,        0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 4'b1010, 3'd0, 1);
    apply("pop_empty",   0, 32'h80000001, 0, 0, 0, 1, 1, 0, 4'h0, 0, 1, 4'b1000, 3'd0, 1);
    apply("push_pre_rst",0, 32'h0,        0, 0, 0, 0, 0, 0, 4'h0, 1, 0, 4'b1000, 3'd1, 1);
    apply("rst_on_push", 1, 32'hFFFFFFFF, 1, 1, 0, 1, 1, 1, 4'b1111, 1, 0, 4'b0000, 3'd0, 0);
    apply("push_after",  0, 32'h0,        0, 0, 0, 0, 0, 0, 4'h0, 1, 0, 4'b0000, 3'd1, 0);
    apply("push_and_pop",0, 32'h0,        0, 0, 0, 0, 1, 1, 4'b1111, 1, 1, 4'b1111, 3'd1, 1);
    apply("pop_last",    0, 32'h0,        0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 4'b0000, 3'd0, 1);
    idle ("final_hold",  4'b0000, 3'd0, 1);

    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #3;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/status_flags_reg.md
Name: status_flags_reg

Overview:
- Producer side of the NZCV condition interface: holds the processor's Negative/Zero/Carry/Overflow flags that the condition evaluator consumes.
- Derives new flags from ALU results on flag-setting instructions. Supports explicit flag writes (MSR-style).
- Keeps a small LIFO of saved flag sets for exception entry/return.
- Sits between the ALU/shifter write-back and the condition-check logic.

Parameters:
- DATA_W, 32, ALU result width used for N/Z derivation.
- STACK_DEPTH, 4, number of saved flag sets (≥1).
- PTR_W, 3, width of depth counter; must satisfy 2^PTR_W > STACK_DEPTH.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- alu_result  in  DATA_W  result from ALU
- alu_carry  in  1  carry-out (arith) or shifter carry (logical)
- alu_overflow  in  1  signed overflow from ALU
- op_logical  in  1  1 = logical op: V is preserved, not updated
- set_flags  in  1  instruction S-bit
- cond_pass  in  1  instruction condition met; gates all updates
- wr_en  in  1  explicit flag write
- wr_flags  in  4  {N,Z,C,V} for explicit write
- push  in  1  save current flags (exception entry)
- pop  in  1  restore flags (exception return)
- flag_n, flag_z, flag_c, flag_v  out  1 each  registered flags
- depth  out  PTR_W  number of saved entries
- stack_full  out  1  depth == STACK_DEPTH
- stack_empty  out  1  depth == 0
- stack_err  out  1  sticky: push when full, pop when empty, or push&pop together

Behaviour:
- Reset (sync, rst=1 at posedge): all flags 0, depth 0, stack_err 0, stack contents don't-care. stack_empty=1, stack_full=0.
- Flags update at the posedge after the inputs are presented; outputs are registered (1-cycle latency).
- ALU update when set_flags & cond_pass:
  - N = alu_result[DATA_W-1]
  - Z = (alu_result == 0)
  - C = alu_carry
  - V = alu_overflow if !op_logical, else unchanged
- Next-flag priority, highest first:
  - pop (valid): flags load the top entry; depth decrements.
  - wr_en & cond_pass: flags = wr_flags.
  - ALU update as above.
  - Otherwise hold.
- push (valid): stack[depth] = current registered flags (the pre-update value in that cycle); depth increments. A simultaneous ALU update or write still applies to the live flags.
- Invalid operations, all leaving stack, depth and flags-from-stack unchanged and setting stack_err=1:
  - push while full
  - pop while empty
  - push & pop in the same cycle
- In these error cases the lower-priority wr_en/ALU update still applies.
- stack_err clears only on rst.
- stack_full/stack_empty are derived from registered depth.
- depth never wraps.
- Reset mid-operation: rst dominates every input in that cycle.

Optional Feature:
- Macro FLAG_BYPASS_EN.
- Defined: additional outputs byp_n, byp_z, byp_c, byp_v combinationally present the next-state flags (same priority logic). This lets a condition check in the same cycle see flags from the preceding flag-setting op without a stall.
- Not defined: byp_* ports are absent; only the registered flags are available, and dependent conditionals see new flags one cycle later.

Decomposition:
- Shared package: flag index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0) and the 4-bit nzcv_t typedef, also used by the condition evaluator.
- One natural sub-module, flag_stack: parameterised LIFO of 4-bit entries with push/pop, depth, full/empty and an error pulse.
- Top level keeps the flag register and priority mux.

Test Plan:
- Reset, then ALU update with alu_result=0x8000_0000, carry=1, ovf=1, op_logical=0, set_flags=1, cond_pass=1 -> next cycle NZCV=1011.
- Logical op with V previously 1: alu_result=0, carry=0, op_logical=1 -> NZCV=0101 (V kept). Same op with cond_pass=0 -> flags unchanged.
- wr_en with wr_flags=0110 plus a simultaneous ALU update (result=0xFFFF_FFFF) -> NZCV=0110 (write wins).
- Push with flags 1010 while an ALU update sets 0100 -> live flags 0100, depth=1; later pop -> flags 1010, depth=0, stack_empty=1.
- Push STACK_DEPTH+1 times -> depth=4, stack_full=1, stack_err=1 on the fifth push; then pop on an empty stack after draining -> stack_err stays 1, depth=0.
- Assert rst during a push -> depth=0, flags 0000, stack_err=0 next cycle.
- With FLAG_BYPASS_EN: byp_* equal the next flags in the same cycle as the ALU update.
